// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared command codes, region codes and state types
// Contents:
//   CMD_PROG / CMD_DATA / CMD_END   command byte values
//   REGION_PROG / REGION_DATA       region bit placed in upg_adr_o[ADDR_W]
//   loader_state_t                  session/word assembly FSM states
//   rx_state_t                      byte receiver FSM states
//   is_region_cmd()                 true for a byte that opens a region transfer
package uart_prog_loader_pkg;

  localparam logic [7:0] CMD_PROG = 8'h00;
  localparam logic [7:0] CMD_DATA = 8'h01;
  localparam logic [7:0] CMD_END  = 8'hFF;

  localparam logic REGION_PROG = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_WORD,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic is_region_cmd(input logic [7:0] b);
    return (b == CMD_PROG) || (b == CMD_DATA);
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - upg_* memory write port shared by loader and memories
// Signals:
//   upg_wen_o   one-cycle write strobe
//   upg_adr_o   {region, word address}, ADDR_W+1 bits
//   upg_dat_o   write data
//   upg_done_o  load session finished, fetch may run
// Modports: master (loader drives), slave (memories / fetch observe)
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);

  logic              upg_wen_o;
  logic [ADDR_W:0]   upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;

  modport master (
    output upg_wen_o,
    output upg_adr_o,
    output upg_dat_o,
    output upg_done_o
  );

  modport slave (
    input upg_wen_o,
    input upg_adr_o,
    input upg_dat_o,
    input upg_done_o
  );

endinterface

// File: rtl/uart_prog_loader_rx_byte.sv
// rtl/uart_prog_loader_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   byte_data    last good byte, held between pulses
//   byte_valid   one-cycle pulse when byte_data is updated
//   stop_err     one-cycle pulse when a stop bit samples low (byte dropped)
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state_q;
  rx_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick;   // current bit's sample point is this cycle

  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        tick = (cnt_q == HALF_LAST);
        // A start bit that is high again at its midpoint was a glitch.
        if (tick) state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        tick = (cnt_q == FULL_LAST);
        if (tick && (bit_q == 3'd7)) state_d = RX_STOP;
      end
      RX_STOP: begin
        tick = (cnt_q == FULL_LAST);
        if (tick) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state_q    <= state_d;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      cnt_q      <= (state_q == RX_IDLE || tick) ? '0 : cnt_q + 1'b1;
      if (state_q == RX_START && tick) bit_q <= 3'd0;
      if (state_q == RX_DATA && tick) begin
        shift_q <= {rx_sync, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
      if (state_q == RX_STOP && tick) begin
        if (rx_sync) begin
          byte_valid <= 1'b1;
          byte_data  <= shift_q;
        end else begin
          stop_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART bootloader producing the upg_* memory write port
// Ports:
//   clk, rst    system clock, synchronous active-low reset
//   rx          UART serial input from host
//   upg         upg_* write port (master modport)
//   busy        high while a region transfer has words outstanding
//   frame_err   one-cycle pulse on bad stop bit or illegal command byte
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int ADDR_W       = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  uart_prog_loader_if.master upg,
  output logic               busy,
  output logic               frame_err
);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          stop_err;

  loader_state_t state_q;
  loader_state_t state_d;
  logic          region_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]   cnt_q;
  logic [31:0]   word_q;
  logic [1:0]    idx_q;
  logic          wen_q;
  logic [ADDR_W:0] adr_q;
  logic [31:0]   dat_q;
  logic          done_q;

  logic          start_session;
  logic          bad_cmd;
  logic          take_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .stop_err  (stop_err)
  );

  always_comb begin
    state_d       = state_q;
    start_session = 1'b0;
    bad_cmd       = 1'b0;
    take_byte     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          if (is_region_cmd(byte_data)) begin
            start_session = 1'b1;
            state_d       = ST_CNT_LO;
          end else if (byte_data == CMD_END) begin
            state_d = ST_DONE;
          end else begin
            bad_cmd = 1'b1;
          end
        end
      end
      ST_CNT_LO: begin
        if (byte_valid) state_d = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (byte_valid) state_d = ({byte_data, cnt_q[7:0]} == 16'd0) ? ST_IDLE : ST_WORD;
      end
      ST_WORD: begin
        if (byte_valid) begin
          take_byte = 1'b1;
          if (idx_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // cnt_q still includes the word being written this cycle.
        state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_WORD;
      end
      ST_DONE: begin
        if (byte_valid && is_region_cmd(byte_data)) begin
          start_session = 1'b1;
          state_d       = ST_CNT_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      region_q  <= REGION_PROG;
      addr_q    <= '0;
      cnt_q     <= 16'd0;
      word_q    <= 32'd0;
      idx_q     <= 2'd0;
      wen_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= 32'd0;
      done_q    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= 1'b0;
      frame_err <= stop_err | bad_cmd;

      if (start_session) begin
        region_q <= (byte_data == CMD_DATA) ? REGION_DATA : REGION_PROG;
        addr_q   <= '0;
        idx_q    <= 2'd0;
        done_q   <= 1'b0;
      end

      if (state_q == ST_IDLE && state_d == ST_DONE) done_q <= 1'b1;

      if (state_q == ST_CNT_LO && byte_valid) cnt_q[7:0] <= byte_data;
      if (state_q == ST_CNT_HI && byte_valid) begin
        cnt_q[15:8] <= byte_data;
        busy        <= (state_d == ST_WORD);
      end

      // Bytes enter at the top so byte k ends up at bits [8k+7:8k].
      if (take_byte) begin
        word_q <= {byte_data, word_q[31:8]};
        idx_q  <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          wen_q <= 1'b1;
          adr_q <= {region_q, addr_q};
          dat_q <= {byte_data, word_q[31:8]};
        end
      end

      if (state_q == ST_WRITE) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 16'd1;
        if (state_d == ST_IDLE) busy <= 1'b0;
      end
    end
  end

  assign upg.upg_wen_o  = wen_q;
  assign upg.upg_adr_o  = adr_q;
  assign upg.upg_dat_o  = dat_q;
  assign upg.upg_done_o = done_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int CPB = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic busy;
  logic frame_err;

  uart_prog_loader_if #(.ADDR_W(14)) upg ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .upg      (upg),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [46:0] obs_q[$];
  int          ferr_cnt   = 0;
  int          double_wen = 0;
  logic        wen_prev   = 1'b0;

  always @(negedge clk) begin
    if (upg.upg_wen_o === 1'b1) obs_q.push_back({upg.upg_adr_o, upg.upg_dat_o});
    if (upg.upg_wen_o === 1'b1 && wen_prev === 1'b1) double_wen++;
    wen_prev = upg.upg_wen_o;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, upg.upg_done_o, busy, frame_err} !== 51'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wen=%b adr=%h dat=%h done=%b busy=%b ferr=%b expected all 0",
               upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, upg.upg_done_o, busy, frame_err);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_two_words();
    int n0 = obs_q.size();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL two_words_busy_start: got %b expected 1", busy); end
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    tests_run++;
    if (obs_q.size() != n0 + 1 || obs_q[n0] !== {15'h0000, 32'hEFBEADDE}) begin
      tests_failed++;
      $display("FAIL two_words_first: got n=%0d w=%h expected n=%0d w=%h", obs_q.size() - n0, obs_q[n0], 1, {15'h0000, 32'hEFBEADDE});
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL two_words_busy_mid: got %b expected 1", busy); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tests_run++;
    if (obs_q.size() != n0 + 2 || obs_q[n0+1] !== {15'h0001, 32'h00000001}) begin
      tests_failed++;
      $display("FAIL two_words_second: got n=%0d w=%h expected n=%0d w=%h", obs_q.size() - n0, obs_q[n0+1], 2, {15'h0001, 32'h00000001});
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL two_words_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_data_region_end();
    int n0 = obs_q.size();
    int f0;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    tests_run++;
    if (obs_q.size() != n0 + 1 || obs_q[n0] !== {15'h4000, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL data_region_write: got n=%0d w=%h expected n=1 w=%h", obs_q.size() - n0, obs_q[n0], {15'h4000, 32'h12345678});
    end
    send_byte(8'hFF);
    tests_run++;
    if (upg.upg_done_o !== 1'b1) begin tests_failed++; $display("FAIL done_after_end: got %b expected 1", upg.upg_done_o); end
    f0 = ferr_cnt;
    send_byte(8'hFF); send_byte(8'h55);
    tests_run++;
    if (upg.upg_done_o !== 1'b1 || ferr_cnt != f0 || obs_q.size() != n0 + 1) begin
      tests_failed++;
      $display("FAIL done_ignores_bytes: got done=%b ferr=%0d writes=%0d expected done=1 ferr=0 writes=1",
               upg.upg_done_o, ferr_cnt - f0, obs_q.size() - n0);
    end
  endtask

  task automatic test_zero_count();
    int n0 = obs_q.size();
    send_byte(8'h00);
    tests_run++;
    if (upg.upg_done_o !== 1'b0) begin tests_failed++; $display("FAIL zero_done_drop: got %b expected 0", upg.upg_done_o); end
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hFF);
    tests_run++;
    if (upg.upg_done_o !== 1'b1 || obs_q.size() != n0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_count: got done=%b writes=%0d busy=%b expected done=1 writes=0 busy=0",
               upg.upg_done_o, obs_q.size() - n0, busy);
    end
  endtask

  task automatic test_bad_cmd_glitch();
    int n0;
    int f0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    f0 = ferr_cnt;
    send_byte(8'h55);
    tests_run++;
    if (ferr_cnt != f0 + 1) begin tests_failed++; $display("FAIL bad_cmd_ferr: got %0d expected 1", ferr_cnt - f0); end
    @(negedge clk) rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tests_run++;
    if (ferr_cnt != f0 + 1 || upg.upg_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_reject: got ferr=%0d done=%b expected ferr=1 done=0", ferr_cnt - f0, upg.upg_done_o);
    end
    n0 = obs_q.size();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    tests_run++;
    if (obs_q.size() != n0 + 1 || obs_q[n0] !== {15'h0000, 32'hDDCCBBAA}) begin
      tests_failed++;
      $display("FAIL after_glitch_write: got n=%0d w=%h expected n=1 w=%h", obs_q.size() - n0, obs_q[n0], {15'h0000, 32'hDDCCBBAA});
    end
  endtask

  task automatic test_stop_err();
    int n0 = obs_q.size();
    int f0;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11);
    f0 = ferr_cnt;
    send_byte(8'h22, 1'b0);
    tests_run++;
    if (ferr_cnt != f0 + 1 || obs_q.size() != n0) begin
      tests_failed++;
      $display("FAIL stop_err_pulse: got ferr=%0d writes=%0d expected ferr=1 writes=0", ferr_cnt - f0, obs_q.size() - n0);
    end
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tests_run++;
    if (obs_q.size() != n0 + 1 || obs_q[n0] !== {15'h0000, 32'h44332211}) begin
      tests_failed++;
      $display("FAIL stop_err_resend: got n=%0d w=%h expected n=1 w=%h", obs_q.size() - n0, obs_q[n0], {15'h0000, 32'h44332211});
    end
  endtask

  task automatic test_reset_mid_word();
    int n0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h99); send_byte(8'h88);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    tests_run++;
    if ({upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, upg.upg_done_o, busy, frame_err} !== 51'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_word_outputs: got wen=%b adr=%h dat=%h done=%b busy=%b ferr=%b expected all 0",
               upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, upg.upg_done_o, busy, frame_err);
    end
    n0 = obs_q.size();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    tests_run++;
    if (obs_q.size() != n0 + 1 || obs_q[n0] !== {15'h0000, 32'h04030201}) begin
      tests_failed++;
      $display("FAIL reset_mid_word_new: got n=%0d w=%h expected n=1 w=%h", obs_q.size() - n0, obs_q[n0], {15'h0000, 32'h04030201});
    end
  endtask

  // Reference: word w of a region transfer lands at region*16384 + w,
  // its value is the little-endian sum of its four bytes.
  task automatic test_random();
    logic [7:0]  bq[$];
    logic [46:0] exp_q[$];
    logic [7:0]  b;
    int          n0;
    int          cnt;
    int          region;
    int unsigned v;
    int unsigned adr;
    for (int s = 0; s < 3; s++) begin
      region = $urandom_range(0, 1);
      cnt    = $urandom_range(1, 3);
      bq.delete();
      exp_q.delete();
      for (int w = 0; w < cnt; w++) begin
        v = 0;
        for (int k = 0; k < 4; k++) begin
          b = 8'($urandom_range(0, 255));
          bq.push_back(b);
          v = v + (32'(b) << (8 * k));
        end
        adr = region * 16384 + (w % 16384);
        exp_q.push_back({15'(adr), v});
      end
      n0 = obs_q.size();
      send_byte(8'(region)); send_byte(8'(cnt)); send_byte(8'h00);
      foreach (bq[i]) send_byte(bq[i]);
      tests_run++;
      if (obs_q.size() != n0 + cnt) begin
        tests_failed++;
        $display("FAIL random_count s=%0d: got %0d expected %0d", s, obs_q.size() - n0, cnt);
      end else begin
        for (int i = 0; i < cnt; i++) begin
          tests_run++;
          if (obs_q[n0+i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL random_word s=%0d i=%0d: got %h expected %h", s, i, obs_q[n0+i], exp_q[i]);
          end
        end
      end
    end
    send_byte(8'hFF);
    tests_run++;
    if (upg.upg_done_o !== 1'b1 || busy !== 1'b0 || double_wen != 0) begin
      tests_failed++;
      $display("FAIL random_end: got done=%b busy=%b double_wen=%0d expected done=1 busy=0 double_wen=0",
               upg.upg_done_o, busy, double_wen);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_data_region_end();
    test_zero_count();
    test_bad_cmd_glitch();
    test_stop_err();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Single-clock UART bootloader that sits directly upstream of the instruction-fetch stage. It deserializes a byte stream from the host, assembles little-endian 32-bit words and produces the upg_* write port consumed by instruction and data memory: upg_wen_o, upg_adr_o, upg_dat_o and upg_done_o. While upg_done_o is low, fetch is held off.

Parameters:
CLKS_PER_BIT, 200, clock cycles per UART bit (23.04 MHz / 115200); must be >= 4.
ADDR_W, 14, word-address width inside one region; upg_adr_o is ADDR_W+1 bits.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous active-low reset.
rx  input  1  UART serial line, idle high, asynchronous to clk.
upg_wen_o  output  1  one-cycle write strobe.
upg_adr_o  output  15  bit 14 = region (0 program, 1 data); bits 13:0 = word address.
upg_dat_o  output  32  write data.
upg_done_o  output  1  high once a load session is finished; CPU may run.
busy  output  1  high while a region transfer is in progress.
frame_err  output  1  one-cycle pulse on a bad stop bit or an illegal command byte.

Behaviour:
- Reset (rst=0 at posedge): every output is 0, both FSMs go to idle, and all counters clear. Reset mid-byte or mid-word discards the partial data.
- rx passes through a 2-flop synchronizer before any use.
- Byte receiver:
  - A falling edge on the synchronized rx starts a byte. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the receiver returns to idle (glitch rejection).
  - The 8 data bits are sampled LSB-first, one every CLKS_PER_BIT cycles after the start-bit midpoint.
  - The stop bit is sampled at its midpoint. If high, a byte-valid pulse is raised for 1 cycle. If low, the byte is dropped and frame_err pulses.
  - The receiver then returns to idle and waits for the next falling edge.
- Protocol: [CMD] [CNT_LO] [CNT_HI] then CNT words of 4 bytes each, little-endian.
  - CMD 0x00 selects the program region; CMD 0x01 selects the data region; CMD 0xFF ends the session.
- Loader FSM states: IDLE, CNT_LO, CNT_HI, WORD, WRITE, DONE.
  - IDLE: on a 0x00/0x01 byte, latch the region bit, clear the word address, clear upg_done_o, and go to CNT_LO. On 0xFF, go to DONE. Any other byte: pulse frame_err and stay in IDLE.
  - CNT_LO, CNT_HI: latch the 16-bit count. If the count is 0, return to IDLE with no write; otherwise go to WORD and raise busy.
  - WORD: shift bytes in, with byte k landing at bits [8k+7:8k]. After the 4th byte, go to WRITE.
  - WRITE: exactly one cycle. upg_wen_o=1, upg_dat_o = assembled word, upg_adr_o = {region, addr}. Next cycle: increment addr (wraps modulo 2^14), decrement count. Go to WORD if count > 0, else to IDLE with busy low.
  - DONE: hold upg_done_o=1. A 0x00/0x01 byte starts a new session exactly as from IDLE, dropping upg_done_o in the same cycle the command is accepted. 0xFF and other bytes are ignored here (no frame_err).
- upg_adr_o and upg_dat_o hold their last values outside WRITE. upg_wen_o is never high for more than 1 cycle.
- Write latency: upg_wen_o rises on the first posedge after the 4th byte's stop-bit sample.
- A framing error inside WORD drops that byte only. The FSM keeps waiting, so the word completes with the next good byte.
- Counts above 16384 wrap the address and overwrite earlier words; this is legal and not flagged.

Decomposition:
- Shared package: CMD_PROG=8'h00, CMD_DATA=8'h01, CMD_END=8'hFF; the loader state enum; REGION_PROG=1'b0, REGION_DATA=1'b1.
- One sub-module: uart_rx_byte, containing the synchronizer, bit timer and shift register. Its outputs are byte[7:0], byte_valid and stop_err.

Test Plan:
1. Send 00 02 00, then DE AD BE EF and 01 00 00 00 -> upg_wen_o pulses twice: adr=0x0000 dat=0xEFBEADDE, then adr=0x0001 dat=0x00000001. busy is high during the transfer and low after.
2. Send 01 01 00 78 56 34 12, then FF -> one write with adr=0x4000 dat=0x12345678. upg_done_o=1 after the FF stop bit and stays high.
3. Send 00 00 00, then FF -> no upg_wen_o pulse; upg_done_o=1.
4. Send byte 0x55 in IDLE -> frame_err pulses once and the state stays IDLE. A 30-cycle low glitch on rx -> no byte is received.
5. Send a byte with the stop bit forced low mid-word -> frame_err pulses and that byte is dropped. A resend completes the word with the correct data.
6. Pull rst low for 1 cycle after 2 of 4 word bytes -> all outputs are 0. A new 00 01 00 + 4-byte frame writes adr=0x0000 with only the new data.
